// File: rtl/ic_pkg.sv
// Shared types and constants for the instruction-cache miss handling block.
//   IC_MSHR_SLOTS   : default number of outstanding miss slots
//   ic_mshr_state_t : per-slot lifecycle state
package ic_pkg;

  localparam int unsigned IC_MSHR_SLOTS = 4;

  // Free -> Pend (allocated) -> Req (on bus) -> Issued (accepted) -> Free (fill returned)
  typedef enum logic [1:0] {
    SlotFree   = 2'd0,
    SlotPend   = 2'd1,
    SlotReq    = 2'd2,
    SlotIssued = 2'd3
  } ic_mshr_state_t;

endpackage

// File: rtl/ic_mshr_if.sv
// Memory-side bus between the miss handler and the line-fill memory port.
//   ic_mem_re/ic_mem_addr/ic_mem_xid : read request (held while not accepted)
//   mem_ic_ready                     : request accepted
//   mem_ic_valid/mem_ic_xid          : fill return for a transaction id
// master = miss handler side, slave = memory side.
interface ic_mshr_if #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned XID_W  = 2
) ();
  logic              ic_mem_re;
  logic [ADDR_W-1:0] ic_mem_addr;
  logic [XID_W-1:0]  ic_mem_xid;
  logic              mem_ic_ready;
  logic              mem_ic_valid;
  logic [XID_W-1:0]  mem_ic_xid;

  modport master (
    output ic_mem_re, ic_mem_addr, ic_mem_xid,
    input  mem_ic_ready, mem_ic_valid, mem_ic_xid
  );

  modport slave (
    input  ic_mem_re, ic_mem_addr, ic_mem_xid,
    output mem_ic_ready, mem_ic_valid, mem_ic_xid
  );
endinterface

// File: rtl/ic_rr_arb.sv
// Round-robin picker: returns the first requesting index at or after 'start',
// wrapping modulo N (N must be a power of two).
//   req       : request vector
//   start     : first index to consider
//   gnt_valid : some request found
//   gnt_idx   : chosen index
module ic_rr_arb #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt_valid = 1'b0;
    gnt_idx   = start;
    idx       = start;
    for (int k = 0; k < int'(N); k++) begin
      // Index arithmetic wraps naturally at IDX_W bits.
      idx = start + IDX_W'(k);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/ic_mshr.sv
// Instruction-cache miss status holding registers.
// Tracks up to N_SLOTS outstanding line misses, merges repeat misses, issues
// one registered read request at a time in round-robin order, matches fill
// returns by transaction id and supports a flush that drops in-flight fills.
//   clk, rst                 : clock, synchronous active-high reset
//   miss_valid/miss_addr     : miss request; miss_ack (comb) when merged/allocated
//   full, pend_cnt           : occupancy
//   mem (ic_mshr_if.master)  : memory read request / fill return bus
//   fill_valid/addr/pf       : combinational fill notification
//   flush, flush_busy        : invalidate pulse and drain indicator
//   err_xid                  : sticky unexpected-return error
// Optional feature: define IC_MSHR_PREFETCH_EN to allocate a next-line
// prefetch slot alongside each demand allocation (fill_pf reports it).
module ic_mshr
  import ic_pkg::*;
#(
  parameter int unsigned N_SLOTS = IC_MSHR_SLOTS,
  parameter int unsigned ADDR_W  = 23,
  localparam int unsigned XID_W  = $clog2(N_SLOTS),
  localparam int unsigned CNT_W  = $clog2(N_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ack,
  output logic              full,
  output logic [CNT_W-1:0]  pend_cnt,
  ic_mshr_if.master         mem,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              fill_pf,
  input  logic              flush,
  output logic              flush_busy,
  output logic              err_xid
);

  ic_mshr_state_t    slot_state_q [N_SLOTS];
  logic [ADDR_W-1:0] slot_addr_q  [N_SLOTS];
  logic [N_SLOTS-1:0] drop_q, drop_d;

  logic              re_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [XID_W-1:0]  req_xid_q;
  logic [XID_W-1:0]  rr_ptr_q;
  logic              err_q;
  logic              busy_q;

  logic [N_SLOTS-1:0] free_vec, pend_vec, inflight_vec, match_vec, arb_req;
  logic [XID_W-1:0]   ret_idx, free_idx, gnt_idx;
  logic               ret_hit, ret_err, free_found, gnt_valid;
  logic               open, merge_hit, alloc, load, accept;

  always_comb begin
    ret_idx  = mem.mem_ic_xid;
    ret_hit  = !rst && mem.mem_ic_valid && (slot_state_q[ret_idx] == SlotIssued);
    ret_err  = !rst && mem.mem_ic_valid && (slot_state_q[ret_idx] != SlotIssued);
    free_vec     = '0;
    pend_vec     = '0;
    inflight_vec = '0;
    match_vec    = '0;
    pend_cnt     = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      free_vec[i]     = (slot_state_q[i] == SlotFree);
      pend_vec[i]     = (slot_state_q[i] == SlotPend);
      inflight_vec[i] = (slot_state_q[i] == SlotReq) || (slot_state_q[i] == SlotIssued);
      // A slot retiring this cycle can no longer absorb a merge.
      match_vec[i]    = !free_vec[i] && !drop_q[i] && (slot_addr_q[i] == miss_addr) &&
                        !(ret_hit && (ret_idx == XID_W'(i)));
      pend_cnt        = pend_cnt + CNT_W'(!free_vec[i]);
      if (!free_found && free_vec[i]) begin
        free_found = 1'b1;
        free_idx   = XID_W'(i);
      end
    end
  end

  // New misses are refused while a flush is requested or still draining.
  assign open      = !rst && !flush && !busy_q;
  assign merge_hit = open && miss_valid && (|match_vec);
  assign alloc     = open && miss_valid && !(|match_vec) && free_found;
  assign miss_ack  = merge_hit || alloc;
  assign full      = ~|free_vec;

  assign fill_valid = ret_hit && !drop_q[ret_idx];
  assign fill_addr  = slot_addr_q[ret_idx];

  always_comb begin
    drop_d = drop_q;
    if (flush) drop_d = drop_d | inflight_vec;
    if (ret_hit) drop_d[ret_idx] = 1'b0;
  end

  // Output registers reload whenever the bus slot is empty or being accepted.
  assign load    = !re_q || mem.mem_ic_ready;
  assign accept  = re_q && mem.mem_ic_ready;
  // Pending slots being flushed this cycle must not be presented.
  assign arb_req = pend_vec & {N_SLOTS{!flush}};

  ic_rr_arb #(
    .N (N_SLOTS)
  ) u_rr_arb (
    .req       (arb_req),
    .start     (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

`ifdef IC_MSHR_PREFETCH_EN
  logic [N_SLOTS-1:0] pf_q;
  logic [ADDR_W-1:0]  pf_addr;
  logic [XID_W-1:0]   pf_idx;
  logic               pf_found, pf_clash, pf_alloc;

  always_comb begin
    pf_addr  = miss_addr + ADDR_W'(1);
    pf_found = 1'b0;
    pf_idx   = '0;
    pf_clash = 1'b0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (!free_vec[i] && (slot_addr_q[i] == pf_addr)) pf_clash = 1'b1;
      // Second-lowest free slot: first free one that the demand miss is not taking.
      if (!pf_found && free_vec[i] && (XID_W'(i) != free_idx)) begin
        pf_found = 1'b1;
        pf_idx   = XID_W'(i);
      end
    end
  end

  assign pf_alloc = alloc && pf_found && !pf_clash;
  assign fill_pf  = fill_valid && pf_q[ret_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        if (alloc && (free_idx == XID_W'(i))) begin
          pf_q[i] <= 1'b0;
        end else if (pf_alloc && (pf_idx == XID_W'(i))) begin
          pf_q[i] <= 1'b1;
        end else if (merge_hit && match_vec[i]) begin
          // Demand caught up with the prefetch: it is a demand fill now.
          pf_q[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign fill_pf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        slot_state_q[i] <= SlotFree;
        slot_addr_q[i]  <= '0;
      end
      drop_q     <= '0;
      re_q       <= 1'b0;
      req_addr_q <= '0;
      req_xid_q  <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        case (slot_state_q[i])
          SlotFree: begin
            if (alloc && (free_idx == XID_W'(i))) begin
              slot_state_q[i] <= SlotPend;
              slot_addr_q[i]  <= miss_addr;
            end
`ifdef IC_MSHR_PREFETCH_EN
            else if (pf_alloc && (pf_idx == XID_W'(i))) begin
              slot_state_q[i] <= SlotPend;
              slot_addr_q[i]  <= pf_addr;
            end
`endif
          end
          SlotPend: begin
            if (flush) begin
              slot_state_q[i] <= SlotFree;
            end else if (load && gnt_valid && (gnt_idx == XID_W'(i))) begin
              slot_state_q[i] <= SlotReq;
            end
          end
          SlotReq: begin
            if (accept && (req_xid_q == XID_W'(i))) slot_state_q[i] <= SlotIssued;
          end
          SlotIssued: begin
            if (ret_hit && (ret_idx == XID_W'(i))) slot_state_q[i] <= SlotFree;
          end
          default: slot_state_q[i] <= SlotFree;
        endcase
      end
      drop_q <= drop_d;
      busy_q <= |drop_d;
      err_q  <= err_q | ret_err;
      if (load) begin
        re_q <= gnt_valid;
        if (gnt_valid) begin
          req_addr_q <= slot_addr_q[gnt_idx];
          req_xid_q  <= gnt_idx;
          rr_ptr_q   <= gnt_idx + XID_W'(1);
        end
      end
    end
  end

  assign mem.ic_mem_re   = re_q;
  assign mem.ic_mem_addr = req_addr_q;
  assign mem.ic_mem_xid  = req_xid_q;
  assign flush_busy      = busy_q;
  assign err_xid         = err_q;

endmodule

// File: tb/tb_ic_mshr.sv
// Directed bench for ic_mshr with a slot-level reference model checked on
// every falling edge, plus hand-computed literal checks per scenario.
module tb_ic_mshr;
  localparam int N  = 4;
  localparam int AW = 23;
  localparam int XW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_valid;
  logic [AW-1:0] miss_addr;
  logic          miss_ack, full, fill_valid, fill_pf, flush, flush_busy, err_xid;
  logic [2:0]    pend_cnt;
  logic [AW-1:0] fill_addr;

  ic_mshr_if #(.ADDR_W(AW), .XID_W(XW)) mem_bus ();

  ic_mshr #(.N_SLOTS(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .miss_ack   (miss_ack),
    .full       (full),
    .pend_cnt   (pend_cnt),
    .mem        (mem_bus),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_pf    (fill_pf),
    .flush      (flush),
    .flush_busy (flush_busy),
    .err_xid    (err_xid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot states 0 free, 1 waiting, 2 on bus, 3 accepted.
  int            ms [N];
  int            ost[N];
  logic [AW-1:0] ma [N];
  bit            md [N];
  bit            mp [N];
  bit            m_re, m_err, m_busy;
  logic [AW-1:0] m_addr;
  int            m_xid, m_ptr;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ack_in_rst", miss_ack, 0);
        chk("fv_in_rst", fill_valid, 0);
        chk("fpf_in_rst", fill_pf, 0);
        for (int i = 0; i < N; i++) begin
          ms[i] = 0; ma[i] = '0; md[i] = 0; mp[i] = 0;
        end
        m_re = 0; m_addr = '0; m_xid = 0; m_ptr = 0; m_err = 0; m_busy = 0;
      end else begin
        int rx, f1, f2, cnt, sel;
        bit ret, mrg, eack, efv, found, clash;
        logic [AW-1:0] a;
        a   = miss_addr;
        rx  = int'(mem_bus.mem_ic_xid);
        ret = mem_bus.mem_ic_valid && ms[rx] == 3;
        efv = ret && !md[rx];
        mrg = 0; f1 = -1; f2 = -1; cnt = 0;
        for (int i = 0; i < N; i++) begin
          if (ms[i] != 0 && !md[i] && ma[i] == a && !(ret && i == rx)) mrg = 1;
          if (ms[i] == 0) begin
            if (f1 < 0) f1 = i;
            else if (f2 < 0) f2 = i;
          end else cnt++;
        end
        eack = miss_valid && !flush && !m_busy && (mrg || f1 >= 0);
        chk("miss_ack", miss_ack, eack);
        chk("full", full, cnt == N);
        chk("pend_cnt", pend_cnt, cnt);
        chk("ic_mem_re", mem_bus.ic_mem_re, m_re);
        if (m_re) begin
          chk("ic_mem_addr", mem_bus.ic_mem_addr, m_addr);
          chk("ic_mem_xid", mem_bus.ic_mem_xid, m_xid);
        end
        chk("flush_busy", flush_busy, m_busy);
        chk("err_xid", err_xid, m_err);
        chk("fill_valid", fill_valid, efv);
        if (efv) chk("fill_addr", fill_addr, ma[rx]);
        chk("fill_pf", fill_pf, efv && mp[rx]);
        // Next state from the start-of-cycle snapshot.
        for (int i = 0; i < N; i++) ost[i] = ms[i];
        if (mem_bus.mem_ic_valid && ost[rx] != 3) m_err = 1;
        if (m_re && mem_bus.mem_ic_ready) ms[m_xid] = 3;
        if (!m_re || mem_bus.mem_ic_ready) begin
          found = 0; sel = 0;
          if (!flush)
            for (int k = 0; k < N; k++)
              if (!found && ost[(m_ptr + k) % N] == 1) begin
                found = 1; sel = (m_ptr + k) % N;
              end
          m_re = found;
          if (found) begin
            ms[sel] = 2; m_addr = ma[sel]; m_xid = sel; m_ptr = (sel + 1) % N;
          end
        end
        if (flush)
          for (int i = 0; i < N; i++) begin
            if (ost[i] == 1) ms[i] = 0;
            if (ost[i] == 2 || ost[i] == 3) md[i] = 1;
          end
        if (ret) begin ms[rx] = 0; md[rx] = 0; end
        if (eack && mrg) begin
          for (int i = 0; i < N; i++)
            if (ost[i] != 0 && !md[i] && ma[i] == a) mp[i] = 0;
        end
        if (eack && !mrg) begin
          ms[f1] = 1; ma[f1] = a; mp[f1] = 0;
`ifdef IC_MSHR_PREFETCH_EN
          clash = 0;
          for (int i = 0; i < N; i++) if (ost[i] != 0 && ma[i] == a + AW'(1)) clash = 1;
          if (f2 >= 0 && !clash) begin
            ms[f2] = 1; ma[f2] = a + AW'(1); mp[f2] = 1;
          end
`else
          clash = (f2 < 0);
`endif
        end
        m_busy = 0;
        for (int i = 0; i < N; i++) if (md[i]) m_busy = 1;
      end
    end
  end

  task automatic set_in(input bit mv, input logic [AW-1:0] a, input bit rdy, input bit rv,
                        input int rx, input bit fl);
    miss_valid           = mv;
    miss_addr            = a;
    mem_bus.mem_ic_ready = rdy;
    mem_bus.mem_ic_valid = rv;
    mem_bus.mem_ic_xid   = XW'(rx);
    flush                = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int xq[$];
  logic [AW-1:0] addr_tab [4];

  initial begin
    addr_tab[0] = 23'h10; addr_tab[1] = 23'h20; addr_tab[2] = 23'h30; addr_tab[3] = 23'h40;
    rst = 1'b1;
    set_in(0, '0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("rst_pend_cnt", pend_cnt, 0);
    chk("rst_re", mem_bus.ic_mem_re, 0);
    chk("rst_err", err_xid, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_full", full, 0);
    tick();

    // Single miss: request two cycles later, then its fill.
    set_in(1, 23'h100, 1, 0, 0, 0); #2 chk("a_ack", miss_ack, 1); tick();
    set_in(0, '0, 1, 0, 0, 0); #2 chk("a_re_n1", mem_bus.ic_mem_re, 0); tick();
    #2;
    chk("a_re_n2", mem_bus.ic_mem_re, 1);
    chk("a_addr", mem_bus.ic_mem_addr, 23'h100);
    chk("a_xid", mem_bus.ic_mem_xid, 0);
    tick();
    set_in(0, '0, 1, 1, 0, 0); #2;
    chk("a_fv", fill_valid, 1);
    chk("a_faddr", fill_addr, 23'h100);
    tick();

    // Fill all slots with the bus stalled, then refuse, merge and drain.
    for (int i = 0; i < 4; i++) begin
      set_in(1, addr_tab[i], 0, 0, 0, 0); tick();
    end
    set_in(1, 23'h50, 0, 0, 0, 0); #2;
    chk("b_full_ack", miss_ack, 0);
    chk("b_full", full, 1);
    tick();
    set_in(1, 23'h20, 0, 0, 0, 0); #2;
    chk("b_merge_ack", miss_ack, 1);
    chk("b_merge_cnt", pend_cnt, 4);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, '0, 0, 0, 0, 0); #2;
      chk("b_stall_re", mem_bus.ic_mem_re, 1);
      chk("b_stall_addr", mem_bus.ic_mem_addr, 23'h10);
      chk("b_stall_xid", mem_bus.ic_mem_xid, 0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      set_in(0, '0, 1, 0, 0, 0); #2;
      if (mem_bus.ic_mem_re === 1'b1) xq.push_back(int'(mem_bus.ic_mem_xid));
      tick();
    end
    chk("b_nissued", xq.size(), 4);
    for (int i = 0; i < xq.size() && i < 4; i++) chk("b_order", xq[i], i);
    for (int x = 0; x < 3; x++) begin
      set_in(0, '0, 1, 1, x, 0); #2;
      chk("b_fv", fill_valid, 1);
      chk("b_faddr", fill_addr, addr_tab[x]);
      tick();
    end
    // Return on slot 3 together with a new allocation.
    set_in(1, 23'h60, 1, 1, 3, 0); #2;
    chk("b_fv3", fill_valid, 1);
    chk("b_faddr3", fill_addr, 23'h40);
    chk("b_ack_sim", miss_ack, 1);
    tick();
    set_in(0, '0, 1, 0, 0, 0); #2 chk("b_cnt_sim", pend_cnt, 1); tick();
    #2;
    chk("b_re60", mem_bus.ic_mem_re, 1);
    chk("b_addr60", mem_bus.ic_mem_addr, 23'h60);
    tick();
    set_in(0, '0, 1, 1, 0, 0); #2 chk("b_fv60", fill_valid, 1); tick();

    // Flush with slots 0,1 accepted and slot 2 waiting.
    set_in(1, 23'h300, 1, 0, 0, 0); tick();
    set_in(1, 23'h310, 1, 0, 0, 0); tick();
    set_in(0, '0, 1, 0, 0, 0); #2 chk("c_xid0", mem_bus.ic_mem_xid, 0); tick();
    #2 chk("c_xid1", mem_bus.ic_mem_xid, 1); tick();
    set_in(1, 23'h320, 1, 0, 0, 0); #2 chk("c_ack", miss_ack, 1); tick();
    set_in(0, '0, 1, 0, 0, 1); #2 chk("c_cnt_pre", pend_cnt, 3); tick();
    set_in(1, 23'h330, 1, 0, 0, 0); #2;
    chk("c_busy", flush_busy, 1);
    chk("c_cnt_post", pend_cnt, 2);
    chk("c_ack_busy", miss_ack, 0);
    tick();
    set_in(0, '0, 1, 1, 1, 0); #2 chk("c_fv_drop1", fill_valid, 0); tick();
    set_in(0, '0, 1, 1, 0, 0); #2;
    chk("c_fv_drop0", fill_valid, 0);
    chk("c_busy_mid", flush_busy, 1);
    tick();
    set_in(0, '0, 1, 0, 0, 0); #2;
    chk("c_busy_end", flush_busy, 0);
    chk("c_cnt_end", pend_cnt, 0);
    tick();

    // Unexpected return sets a sticky error.
    set_in(0, '0, 1, 1, 3, 0); tick();
    set_in(1, 23'h400, 1, 0, 0, 0); #2 chk("d_err_set", err_xid, 1); tick();
    set_in(0, '0, 1, 0, 0, 0); tick();
    #2 chk("d_addr400", mem_bus.ic_mem_addr, 23'h400); tick();
    set_in(0, '0, 1, 1, 0, 0); #2;
    chk("d_fv400", fill_valid, 1);
    chk("d_err_held", err_xid, 1);
    tick();
    // Reset mid-transaction; the old id then becomes an error.
    set_in(1, 23'h500, 1, 0, 0, 0); tick();
    set_in(0, '0, 1, 0, 0, 0); tick();
    tick();
    rst = 1'b1;
    set_in(1, 23'h510, 1, 1, 0, 0); #2 chk("d_ack_rst", miss_ack, 0); tick();
    rst = 1'b0;
    set_in(0, '0, 1, 1, 0, 0); #2;
    chk("d_err_clr", err_xid, 0);
    chk("d_cnt_clr", pend_cnt, 0);
    chk("d_fv_old", fill_valid, 0);
    tick();
    set_in(0, '0, 1, 0, 0, 0); #2 chk("d_err_old", err_xid, 1); tick();

`ifdef IC_MSHR_PREFETCH_EN
    set_in(1, 23'h80, 1, 0, 0, 0); #2 chk("e_ack", miss_ack, 1); tick();
    set_in(0, '0, 1, 0, 0, 0); #2 chk("e_cnt", pend_cnt, 2); tick();
    #2 chk("e_addr80", mem_bus.ic_mem_addr, 23'h80); tick();
    #2 chk("e_addr81", mem_bus.ic_mem_addr, 23'h81); tick();
    set_in(0, '0, 1, 1, 1, 0); #2;
    chk("e_faddr81", fill_addr, 23'h81);
    chk("e_pf81", fill_pf, 1);
    tick();
    set_in(0, '0, 1, 1, 0, 0); #2 chk("e_pf80", fill_pf, 0); tick();
`endif

    set_in(0, '0, 1, 0, 0, 0);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
